// File: rtl/irq_arbiter_pkg.sv
// Shared interrupt definitions: FSM encoding, default id width and source numbering
// used by the arbiter, the PC unit and software.
package irq_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   localparam int DEF_NUM_SRC = 8;
   localparam int DEF_ID_W    = 8;

   // Source numbering; lower index means higher fixed priority.
   localparam int SRC_TIMER = 0;
   localparam int SRC_UART  = 1;
   localparam int SRC_EXT0  = 2;
   localparam int SRC_EXT1  = 3;
   localparam int SRC_EXT2  = 4;
   localparam int SRC_EXT3  = 5;
   localparam int SRC_EXT4  = 6;
   localparam int SRC_EXT5  = 7;

endpackage

// File: rtl/irq_arbiter_edge_detect.sv
// Per-source optional synchroniser plus rising-edge detector; SYNC_STAGES cycles of latency,
// edge output is combinational from the last stage. No backpressure.
module irq_arbiter_edge_detect #(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic [NUM_SRC-1:0] irq_edge
);

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic s;
      logic prev_q;

      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = irq_in[i];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= irq_in[i];
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end

      // prev clears on reset so a line held high through reset yields one event.
      always_ff @(posedge clk) begin
         if (reset) prev_q <= 1'b0;
         else       prev_q <= s;
      end

      assign irq_edge[i] = s & ~prev_q;
   end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latched, maskable interrupt arbiter presenting one registered request/id to the PC unit;
// request one cycle after pending; held until int_ack, service held until int_done.
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int NUM_SRC     = DEF_NUM_SRC,
   parameter int ID_W        = DEF_ID_W,
   parameter int SYNC_STAGES = 0,
   parameter int ROUND_ROBIN = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask_q,
   output logic [NUM_SRC-1:0] pending_q,
   output logic               int_req,
   output logic [ID_W-1:0]    int_id,
   input  logic               int_ack,
   input  logic               int_done,
   output logic               busy
);

   irq_state_t         state_q, state_d;
   logic               int_req_q, int_req_d;
   logic [ID_W-1:0]    int_id_q, int_id_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_SRC-1:0] irq_edge;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    win_id, hi_id, lo_id;
   logic               hi_found;

   irq_arbiter_edge_detect #(
      .NUM_SRC     (NUM_SRC),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .irq_edge (irq_edge)
   );

   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         clr[i] = (state_q == ST_REQ) && int_ack && (int_id_q == ID_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q    <= '1;
         pending_q <= '0;
      end else begin
         if (mask_we) mask_q <= mask_wdata;
         // Set wins over clear so an edge arriving in the ack cycle is kept.
         pending_q <= (pending_q & ~clr) | irq_edge;
      end
   end

   assign eligible = pending_q & mask_q;

   // Descending scan leaves the lowest qualifying index; hi_* only counts indices at/after rr_ptr.
   always_comb begin
      hi_found = 1'b0;
      hi_id    = '0;
      lo_id    = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            lo_id = ID_W'(i);
            if (ROUND_ROBIN != 0 && ID_W'(i) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_id    = ID_W'(i);
            end
         end
      end
      win_id = hi_found ? hi_id : lo_id;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         int_req_q <= 1'b0;
         int_id_q  <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         int_req_q <= int_req_d;
         int_id_q  <= int_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      int_req_d = int_req_q;
      int_id_d  = int_id_q;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d   = ST_REQ;
               int_req_d = 1'b1;
               int_id_d  = win_id;
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               state_d   = ST_SERVICE;
               int_req_d = 1'b0;
               if (ROUND_ROBIN != 0) begin
                  rr_ptr_d = (int_id_q == ID_W'(NUM_SRC - 1)) ? '0 : int_id_q + ID_W'(1);
               end
            end
         end
         ST_SERVICE: begin
            if (int_done) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            int_req_d = 1'b0;
         end
      endcase
   end

   assign int_req = int_req_q;
   assign int_id  = int_id_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
